// File: rtl/fft4_frame_if.sv
// Handshake bundle for the 4-point FFT frame controller.
// Sample input port, bin output port and busy status.
interface fft4_frame_if #(
  parameter int DW = 2,
  parameter int OW = DW + 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_re;
  logic signed [OW-1:0] out_im;
  logic [1:0]           out_idx;
  logic                 out_last;
  logic                 busy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_re, out_im,
    output out_idx, out_last, busy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_re, out_im,
    input  out_idx, out_last, busy
  );
endinterface

// File: rtl/fft4_frame_ctrl.sv
// Streaming frame controller around a radix-4 4-point FFT butterfly.
// Optional FFT4_BITREV_EN: emit bins in bit-reversed order 0,2,1,3.
module fft4_frame_ctrl #(
  parameter int DW = 2,
  parameter int OW = DW + 2
) (
  input logic         clk,
  input logic         rst_n,
  fft4_frame_if.slave bus
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    COMPUTE = 2'd1,
    EMIT    = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] seq_q, seq_d;
  logic [1:0] k;

  logic signed [DW-1:0] samp_q [4];
  logic signed [OW-1:0] re_q [4];
  logic signed [OW-1:0] im_q [4];
  logic signed [OW-1:0] xe [4];
  logic signed [OW-1:0] br [4];
  logic signed [OW-1:0] bi [4];

  logic in_fire;
  logic out_fire;

  assign in_fire  = bus.in_valid && (state_q == COLLECT);
  assign out_fire = bus.out_ready && (state_q == EMIT);

`ifdef FFT4_BITREV_EN
  assign k = {seq_q[0], seq_q[1]};
`else
  assign k = seq_q;
`endif

  // State and counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      cnt_q   <= 2'd0;
      seq_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seq_q   <= seq_d;
    end
  end

  // Next-state: collect 4, compute once, emit 4
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seq_d   = seq_q;
    case (state_q)
      COLLECT: begin
        if (in_fire) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        seq_d   = 2'd0;
        state_d = EMIT;
      end
      EMIT: begin
        if (out_fire) begin
          seq_d = seq_q + 2'd1;
          if (seq_q == 2'd3) state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Butterfly on sign-extended samples
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      xe[i] = {{(OW-DW){samp_q[i][DW-1]}}, samp_q[i]};
    end
    br[0] = xe[0] + xe[1] + xe[2] + xe[3];
    bi[0] = '0;
    br[1] = xe[0] - xe[2];
    bi[1] = xe[3] - xe[1];
    br[2] = xe[0] + xe[2] - xe[1] - xe[3];
    bi[2] = '0;
    br[3] = xe[0] - xe[2];
    bi[3] = xe[1] - xe[3];
  end

  // Sample capture and bin latching
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        samp_q[i] <= '0;
        re_q[i]   <= '0;
        im_q[i]   <= '0;
      end
    end else begin
      if (in_fire) samp_q[cnt_q] <= bus.in_data;
      if (state_q == COMPUTE) begin
        for (int i = 0; i < 4; i++) begin
          re_q[i] <= br[i];
          im_q[i] <= bi[i];
        end
      end
    end
  end

  assign bus.in_ready  = (state_q == COLLECT);
  assign bus.busy      = (state_q != COLLECT);
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_re    = bus.out_valid ? re_q[k] : '0;
  assign bus.out_im    = bus.out_valid ? im_q[k] : '0;
  assign bus.out_idx   = bus.out_valid ? k : 2'd0;
  assign bus.out_last  = bus.out_valid && (seq_q == 2'd3);

endmodule

// File: tb/tb_fft4_frame_ctrl.sv
// Directed bench for fft4_frame_ctrl (DW=2, OW=4).
// Drives and samples on the falling edge.
module tb_fft4_frame_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic hold_ready = 1'b0;

  int sx [4];
  int ere [4];
  int eim [4];
  int ord [4];

  fft4_frame_if #(.DW(2), .OW(4)) bus ();

  fft4_frame_ctrl #(.DW(2), .OW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic put(input int x);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = 2'(x);
    n = 0;
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("in_timeout", 1, 0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic take(input string tag, input int k, input int last);
    int n;
    bus.out_ready = 1'b1;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk({tag, "_timeout"}, 1, 0);
    chk({tag, "_re"}, int'(bus.out_re), ere[k]);
    chk({tag, "_im"}, int'(bus.out_im), eim[k]);
    chk({tag, "_idx"}, int'(bus.out_idx), k);
    chk({tag, "_last"}, int'(bus.out_last), last);
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = hold_ready;
  endtask

  task automatic frame(input string tag, input int gap);
    for (int i = 0; i < 4; i++) begin
      if (gap != 0) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
      put(sx[i]);
    end
    for (int j = 0; j < 4; j++) begin
      if (gap != 0 && j[0]) begin
        bus.out_ready = 1'b0;
        @(negedge clk);
      end
      take($sformatf("%s_b%0d", tag, j), ord[j], (j == 3) ? 1 : 0);
    end
  endtask

  task automatic set4(input int a, input int b, input int c,
                      input int d, output int v [4]);
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
  endtask

  initial begin
`ifdef FFT4_BITREV_EN
    set4(0, 2, 1, 3, ord);
`else
    set4(0, 1, 2, 3, ord);
`endif
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst0_in_ready", int'(bus.in_ready), 1);
    chk("rst0_out_valid", int'(bus.out_valid), 0);
    chk("rst0_busy", int'(bus.busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // T2 DC with out_ready high throughout
    set4(1, 1, 1, 1, sx);
    set4(4, 0, 0, 0, ere);
    set4(0, 0, 0, 0, eim);
    hold_ready = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) put(sx[i]);
    chk("t2_compute_valid", int'(bus.out_valid), 0);
    chk("t2_compute_busy", int'(bus.busy), 1);
    chk("t2_compute_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    chk("t2_lat_valid", int'(bus.out_valid), 1);
    for (int j = 0; j < 4; j++)
      take($sformatf("t2_b%0d", j), ord[j], (j == 3) ? 1 : 0);
    chk("t2_end_valid", int'(bus.out_valid), 0);
    chk("t2_end_ready", int'(bus.in_ready), 1);
    hold_ready = 1'b0;
    bus.out_ready = 1'b0;

    // T1 reset during EMIT
    set4(1, 0, 1, 0, sx);
    for (int i = 0; i < 4; i++) put(sx[i]);
    @(negedge clk);
    chk("t1_pre_valid", int'(bus.out_valid), 1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t1_in_ready", int'(bus.in_ready), 1);
    chk("t1_out_valid", int'(bus.out_valid), 0);
    chk("t1_out_re", int'(bus.out_re), 0);
    chk("t1_out_im", int'(bus.out_im), 0);
    chk("t1_out_idx", int'(bus.out_idx), 0);
    chk("t1_out_last", int'(bus.out_last), 0);
    chk("t1_busy", int'(bus.busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Mid-frame reset discards the partial frame
    put(-2);
    put(-2);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // T3 mixed
    set4(1, -2, 0, 1, sx);
    set4(0, 1, 2, 1, ere);
    set4(0, 3, 0, -3, eim);
    frame("t3", 0);

    // T4 most negative input
    set4(-2, -2, -2, -2, sx);
    set4(-8, 0, 0, 0, ere);
    set4(0, 0, 0, 0, eim);
    frame("t4", 0);

    // T5 stall on the second emitted bin; input ignored meanwhile
    set4(1, 0, -1, 0, sx);
    set4(0, 2, 0, 2, ere);
    set4(0, 0, 0, 0, eim);
    for (int i = 0; i < 4; i++) put(sx[i]);
    take("t5_b0", ord[0], 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 2'b01;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("t5_hold%0d_re", c), int'(bus.out_re), ere[ord[1]]);
      chk($sformatf("t5_hold%0d_idx", c), int'(bus.out_idx), ord[1]);
      chk($sformatf("t5_hold%0d_valid", c), int'(bus.out_valid), 1);
      chk($sformatf("t5_hold%0d_in_ready", c), int'(bus.in_ready), 0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    for (int j = 1; j < 4; j++)
      take($sformatf("t5_b%0d", j), ord[j], (j == 3) ? 1 : 0);

    // T6 gapped input and stalled output, two frames
    set4(0, 1, 1, -1, sx);
    set4(1, -1, 1, -1, ere);
    set4(0, -2, 0, 2, eim);
    frame("t6a", 1);
    set4(-1, 1, -2, 1, sx);
    set4(-1, 1, -5, 1, ere);
    set4(0, 0, 0, 0, eim);
    frame("t6b", 1);
    chk("t6_end_ready", int'(bus.in_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
